// File: rtl/pdl_meas.sv
// Pulse delay/width measurement.
// Measures, in clk cycles, the delay from a trigger rising edge to the next pulse rising edge,
// and the width of that pulse. Results update together with a one-cycle valid strobe.
module pdl_meas #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic             enable,
    input  logic             trigger,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] timeout,      // 0 disables the per-phase timeout
    output logic [WIDTH-1:0] dl_meas,
    output logic [WIDTH-1:0] wb_meas,
    output logic             valid,
    output logic             timeout_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StWaitFall
    } state_e;

    state_e           state_q, state_d;
    logic             trig_q, pulse_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dl_hold_q, dl_hold_d;
    logic [WIDTH-1:0] dl_q, dl_d;
    logic [WIDTH-1:0] wb_q, wb_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             trig_rise;
    logic             pulse_rise;
    logic             pulse_fall;
    logic [WIDTH-1:0] cnt_inc;
    logic             timeout_hit;

    assign trig_rise  = trigger & ~trig_q;
    assign pulse_rise = pulse_in & ~pulse_q;
    assign pulse_fall = ~pulse_in & pulse_q;

    // cnt_inc is the cycle count as of the current edge; saturates instead of wrapping
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (timeout != '0) && (cnt_inc >= timeout);

    // Next-state, counter and output strobe decode; qualifying edges win over timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dl_hold_d = dl_hold_q;
        dl_d      = dl_q;
        wb_d      = wb_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && trig_rise) begin
                    state_d = StWaitRise;
                    cnt_d   = '0;
                end
            end
            StWaitRise: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (pulse_rise) begin
                    dl_hold_d = cnt_inc;
                    cnt_d     = '0;
                    state_d   = StWaitFall;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitFall: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (pulse_fall) begin
                    dl_d    = dl_hold_q;
                    wb_d    = cnt_inc;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State, edge-detect history and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            trig_q    <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
            dl_hold_q <= '0;
            dl_q      <= '0;
            wb_q      <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trigger;
            pulse_q   <= pulse_in;
            cnt_q     <= cnt_d;
            dl_hold_q <= dl_hold_d;
            dl_q      <= dl_d;
            wb_q      <= wb_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign dl_meas     = dl_q;
    assign wb_meas     = wb_q;
    assign valid       = valid_q;
    assign timeout_err = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pdl_meas.sv
// Scoreboard bench for pdl_meas: stimulus pushes expected strobes, a negedge monitor checks them.
module tb_pdl_meas;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        trigger;
    logic        pulse_in;
    logic [31:0] timeout;
    logic [31:0] dl_meas;
    logic [31:0] wb_meas;
    logic        valid;
    logic        timeout_err;
    logic        busy;

    typedef struct {
        bit          err;
        logic [31:0] dl;
        logic [31:0] wb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_dl = 0;
    logic [31:0] last_wb = 0;

    pdl_meas #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .trigger    (trigger),
        .pulse_in   (pulse_in),
        .timeout    (timeout),
        .dl_meas    (dl_meas),
        .wb_meas    (wb_meas),
        .valid      (valid),
        .timeout_err(timeout_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; they are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger rise at edge k, pulse rise at edge k+d, pulse fall at edge k+d+w.
    task automatic meas(input int d, input int w);
        sb.push_back('{1'b0, d, w});
        last_dl = d;
        last_wb = w;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("busy_start", {31'd0, busy}, 32'd1);
        repeat (d - 1) tick();
        pulse_in = 1'b1;
        repeat (w) tick();
        pulse_in = 1'b0;
        tick();
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (valid || timeout_err) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got valid=%0b timeout_err=%0b, expected none (t=%0t)",
                         valid, timeout_err, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_err", {31'd0, timeout_err}, {31'd0, mon_e.err});
                chk("strobe_valid", {31'd0, valid}, {31'd0, !mon_e.err});
                chk("dl_meas", dl_meas, mon_e.dl);
                chk("wb_meas", wb_meas, mon_e.wb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        trigger  = 1'b0;
        pulse_in = 1'b0;
        timeout  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dl", dl_meas, 32'd0);
        chk("rst_wb", wb_meas, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Basic measurement, then results held while idle
        meas(10, 10);
        repeat (4) tick();
        chk("hold_dl", dl_meas, 32'd10);
        chk("hold_wb", wb_meas, 32'd10);

        // Second measurement, then back-to-back minimum delay/width with zero idle cycles
        meas(18, 16);
        meas(1, 1);
        tick();

        // Timeout in WAIT_RISE: strobe exactly 5 cycles after the trigger edge
        timeout = 32'd5;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        sb.push_back('{1'b1, last_dl, last_wb});
        repeat (4) tick();
        chk("tmo_early", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("tmo_strobe", {31'd0, timeout_err}, 32'd1);
        tick();
        chk("tmo_one_cycle", {31'd0, timeout_err}, 32'd0);
        chk("tmo_busy", {31'd0, busy}, 32'd0);

        // Edges landing exactly on the timeout count win
        meas(5, 5);
        timeout = 32'd0;
        tick();

        // Pulse already high at trigger: must fall and rise again; delay keeps counting
        pulse_in = 1'b1;
        tick();
        sb.push_back('{1'b0, 32'd7, 32'd4});
        last_dl = 7;
        last_wb = 4;
        trigger = 1'b1;
        tick();                      // edge k
        trigger = 1'b0;
        repeat (2) tick();           // k+1, k+2 high
        pulse_in = 1'b0;
        repeat (4) tick();           // k+3..k+6 low
        pulse_in = 1'b1;
        repeat (4) tick();           // k+7..k+10 high
        pulse_in = 1'b0;
        tick();                      // k+11 fall
        tick();

        // Extra trigger rises during WAIT_FALL are ignored; trigger held high does not retrigger
        sb.push_back('{1'b0, 32'd3, 32'd6});
        last_dl = 3;
        last_wb = 6;
        trigger = 1'b1;
        tick();                      // k
        trigger = 1'b0;
        repeat (2) tick();           // k+1, k+2
        pulse_in = 1'b1;
        tick();                      // k+3 rise
        trigger = 1'b1;
        tick();                      // k+4
        trigger = 1'b0;
        tick();                      // k+5
        trigger = 1'b1;
        repeat (3) tick();           // k+6..k+8
        pulse_in = 1'b0;
        tick();                      // k+9 fall
        repeat (3) tick();
        chk("no_retrig_busy", {31'd0, busy}, 32'd0);
        trigger = 1'b0;
        tick();

        // Enable dropped mid-WAIT_RISE: abort silently, outputs held
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        chk("en_abort_busy", {31'd0, busy}, 32'd0);
        pulse_in = 1'b1;
        repeat (3) tick();
        pulse_in = 1'b0;
        repeat (3) tick();
        chk("en_abort_dl", dl_meas, last_dl);
        chk("en_abort_wb", wb_meas, last_wb);
        enable = 1'b1;
        tick();

        // Asynchronous reset mid-WAIT_FALL clears everything immediately
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        pulse_in = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_dl", dl_meas, 32'd0);
        chk("arst_wb", wb_meas, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        last_dl  = 0;
        last_wb  = 0;
        pulse_in = 1'b0;
        @(negedge clk) reset = 1'b1;
        tick();
        meas(4, 2);
        tick();

        // Every expected strobe must have appeared
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
